// File: rtl/serial_receiver.sv
// serial_receiver: asynchronous serial (UART-style) receiver with a valid/ready output.
//
// Frames are: one start bit (low), WIDTH data bits LSB first, an optional parity bit,
// and STOP stop bits (high). The line is oversampled by a bit timer of DIV = FREQ/BAUD
// (rounded) clock cycles, and each bit is sampled in its middle.
//
// Parameters:
//   FREQ   - clock frequency in Hz
//   BAUD   - line rate in bit/s
//   WIDTH  - data bits per frame (5..9)
//   PARITY - 0 none, 1 odd, 2 even
//   STOP   - stop bits per frame (1 or 2)
//
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   rxd          - asynchronous serial line, idle high
//   data         - received word
//   valid        - data holds a word not yet taken by the consumer
//   ready        - consumer takes data when valid && ready
//   parity_error - one-cycle pulse with a delivered word whose parity bit was wrong
//   frame_error  - one-cycle pulse when a stop bit is sampled low (word dropped)
//   overrun      - one-cycle pulse when an untaken word is overwritten
module serial_receiver #(
  parameter int unsigned FREQ   = 12000000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PARITY = 0,
  parameter int unsigned STOP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             parity_error,
  output logic             frame_error,
  output logic             overrun
);

  localparam int unsigned DIV = (FREQ + BAUD / 2) / BAUD;
  localparam int unsigned TW  = $clog2(DIV) + 1;
  localparam int unsigned BW  = $clog2(WIDTH + 1);

  localparam logic [TW-1:0] DivT      = TW'(DIV);
  localparam logic [TW-1:0] HalfT     = TW'(DIV / 2);
  localparam logic [BW-1:0] LastData  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LastStop  = BW'(STOP - 1);

  if (DIV < 4 || WIDTH < 5 || WIDTH > 9 || PARITY > 2 || (STOP != 1 && STOP != 2))
  begin : g_param_check
    $error("serial_receiver: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  // Registers
  logic [1:0]       r_sync;
  logic             r_line_prev;
  state_e           r_state;
  logic [TW-1:0]    r_timer;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par_pend;

  // Next-state and control
  logic             w_line;
  logic             w_tick;
  logic             w_par_bad;
  state_e           w_state_d;
  logic [TW-1:0]    w_timer_d;
  logic [BW-1:0]    w_bitcnt_d;
  logic [WIDTH-1:0] w_shift_d;
  logic             w_par_pend_d;
  logic             w_deliver;
  logic             w_frame_err;
  logic             w_par_err;

  assign w_line = r_sync[1];
  // Timer is always loaded with a value >= 2, so <= 1 marks the sample point.
  assign w_tick = (r_timer <= TW'(1));
  // Odd parity expects an odd count of ones over data plus parity bit, even expects even.
  assign w_par_bad = (PARITY == 1) ? ~(^r_shift ^ w_line) : (^r_shift ^ w_line);

  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer;
    w_bitcnt_d   = r_bitcnt;
    w_shift_d    = r_shift;
    w_par_pend_d = r_par_pend;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
    w_par_err    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (r_line_prev && !w_line) begin
          w_bitcnt_d   = '0;
          w_timer_d    = HalfT;
          w_par_pend_d = 1'b0;
          w_state_d    = StStart;
        end
      end
      StStart: begin
        if (w_tick) begin
          if (!w_line) begin
            w_timer_d = DivT;
            w_state_d = StData;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            w_state_d = StIdle;
          end
        end else begin
          w_timer_d = r_timer - TW'(1);
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_d = {w_line, r_shift[WIDTH-1:1]};
          w_timer_d = DivT;
          if (r_bitcnt == LastData) begin
            w_bitcnt_d = '0;
            w_state_d  = (PARITY != 0) ? StParity : StStop;
          end else begin
            w_bitcnt_d = r_bitcnt + BW'(1);
          end
        end else begin
          w_timer_d = r_timer - TW'(1);
        end
      end
      StParity: begin
        if (w_tick) begin
          w_par_pend_d = w_par_bad;
          w_timer_d    = DivT;
          w_bitcnt_d   = '0;
          w_state_d    = StStop;
        end else begin
          w_timer_d = r_timer - TW'(1);
        end
      end
      StStop: begin
        if (w_tick) begin
          if (!w_line) begin
            w_frame_err = 1'b1;
            w_state_d   = StBreak;
          end else if (r_bitcnt == LastStop) begin
            w_deliver = 1'b1;
            w_par_err = r_par_pend;
            w_state_d = StIdle;
          end else begin
            w_bitcnt_d = r_bitcnt + BW'(1);
            w_timer_d  = DivT;
          end
        end else begin
          w_timer_d = r_timer - TW'(1);
        end
      end
      StBreak: begin
        // Wait for the line to return high so a held-low line cannot start a frame.
        if (w_line) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync       <= 2'b11;
      r_line_prev  <= 1'b1;
      r_state      <= StIdle;
      r_timer      <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_pend   <= 1'b0;
      data         <= '0;
      valid        <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], rxd};
      r_line_prev  <= w_line;
      r_state      <= w_state_d;
      r_timer      <= w_timer_d;
      r_bitcnt     <= w_bitcnt_d;
      r_shift      <= w_shift_d;
      r_par_pend   <= w_par_pend_d;
      parity_error <= w_par_err;
      frame_error  <= w_frame_err;
      // A word taken in the same cycle as a new delivery is not an overrun.
      overrun      <= w_deliver && valid && !ready;
      if (w_deliver) begin
        data  <= r_shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: three instances (default 8N1 at 1250 clk/bit, a fast 8N1 at
// 16 clk/bit, and a fast 8E1). Stimulus pushes expected events into per-instance queues;
// a negedge monitor pops and compares whenever an instance delivers a word or pulses an
// error.
module tb_serial_receiver;

  localparam int D0 = 1250;
  localparam int D1 = 16;

  typedef struct packed {
    logic       fe;
    logic [7:0] d;
    logic       pe;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxd = 3'b111;
  logic [2:0] ready = 3'b111;

  logic [7:0] data0, data1, data2;
  logic       valid0, valid1, valid2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic       ovr0, ovr1, ovr2;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc0 = 0;
  int del_cyc0 = 0;
  bit [2:0] pv = '0;
  bit [2:0] pr = '0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_receiver u_d0 (
    .clk(clk), .rst(rst), .rxd(rxd[0]), .data(data0), .valid(valid0), .ready(ready[0]),
    .parity_error(perr0), .frame_error(ferr0), .overrun(ovr0)
  );

  serial_receiver #(.FREQ(160000), .BAUD(10000)) u_d1 (
    .clk(clk), .rst(rst), .rxd(rxd[1]), .data(data1), .valid(valid1), .ready(ready[1]),
    .parity_error(perr1), .frame_error(ferr1), .overrun(ovr1)
  );

  serial_receiver #(.FREQ(160000), .BAUD(10000), .PARITY(2)) u_d2 (
    .clk(clk), .rst(rst), .rxd(rxd[2]), .data(data2), .valid(valid2), .ready(ready[2]),
    .parity_error(perr2), .frame_error(ferr2), .overrun(ovr2)
  );

  function automatic exp_t mk(logic fe, logic [7:0] d, logic pe, logic ov);
    exp_t e;
    e.fe = fe;
    e.d  = d;
    e.pe = pe;
    e.ov = ov;
    return e;
  endfunction

  function automatic logic [15:0] fr(logic [7:0] d, logic stopb);
    return {6'b0, stopb, d, 1'b0};
  endfunction

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(int i, output exp_t e, output bit ok);
    ok = (qsize(i) != 0);
    e  = '0;
    if (ok) begin
      case (i)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Delivery = valid rising, valid held after a handshake, or an overwrite.
  task automatic mon(int i, logic v, logic [7:0] d, logic pe, logic fe, logic ov, logic rdy);
    exp_t e;
    bit   ok;
    bit   ev;
    ev = v && (!pv[i] || pr[i] || ov);
    if (fe) begin
      pop(i, e, ok);
      n_vec++;
      if (!ok || !e.fe) begin
        n_bad++;
        $display("FAIL frame_error[%0d]: got pulse, required %s", i,
                 ok ? "a delivery" : "no event");
      end
    end
    if (ev) begin
      pop(i, e, ok);
      n_vec++;
      if (!ok || e.fe || e.d !== d || e.pe !== pe || e.ov !== ov) begin
        n_bad++;
        $display("FAIL deliver[%0d]: got data=%h pe=%b ov=%b, required data=%h pe=%b ov=%b fe=%b queued=%b",
                 i, d, pe, ov, e.d, e.pe, e.ov, e.fe, ok);
      end
      if (i == 0) del_cyc0 = cyc;
    end else if (pe || ov) begin
      n_vec++;
      n_bad++;
      $display("FAIL stray_pulse[%0d]: got pe=%b ov=%b without delivery, required 0", i, pe, ov);
    end
    pv[i] = v;
    pr[i] = rdy;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv = '0;
    end else begin
      mon(0, valid0, data0, perr0, ferr0, ovr0, ready[0]);
      mon(1, valid1, data1, perr1, ferr1, ovr1, ready[1]);
      mon(2, valid2, data2, perr2, ferr2, ovr2, ready[2]);
    end
  end

  // Drive bits[first..last], each held div cycles; leaves the line at the last bit.
  task automatic send(int i, int div, int first, int last, logic [15:0] bits);
    for (int k = first; k <= last; k++) begin
      rxd[i] = bits[k];
      if (i == 0 && k == 0) start_cyc0 = cyc;
      repeat (div) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(int i, int n);
    rxd[i] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(int i, int budget);
    int n = 0;
    while (qsize(i) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (qsize(i) != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout[%0d]: %0d events still pending, required 0", i, qsize(i));
    end
  endtask

  initial begin
    int lat;

    // Reset values right after release
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_d0", {valid0, perr0, ferr0, ovr0, data0}, '0);
    chk("reset_d1", {valid1, perr1, ferr1, ovr1, data1}, '0);
    chk("reset_d2", {valid2, perr2, ferr2, ovr2, data2}, '0);
    @(posedge clk);
    #1;

    // 0xA5 8N1 at 1250 clk/bit; delivery about 9.5 bit times plus sync delay after start
    push(0, mk(1'b0, 8'hA5, 1'b0, 1'b0));
    send(0, D0, 0, 9, fr(8'hA5, 1'b1));
    idle(0, D0);
    wait_drain(0, 2 * D0);
    lat = del_cyc0 - start_cyc0;
    chk("a5_latency_in_window", {31'b0, (lat >= 11874 && lat <= 11882)}, 32'd1);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
    push(2, mk(1'b0, 8'h03, 1'b1, 1'b0));
    send(2, D1, 0, 10, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0});
    idle(2, 2 * D1);
    push(2, mk(1'b0, 8'h03, 1'b0, 1'b0));
    send(2, D1, 0, 10, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0});
    idle(2, 2 * D1);
    push(2, mk(1'b0, 8'h07, 1'b0, 1'b0));
    send(2, D1, 0, 10, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0});
    idle(2, 2 * D1);
    wait_drain(2, 4 * D1);

    // Stop bit low then line held low 20 bit times, then a good frame
    push(1, mk(1'b1, 8'h00, 1'b0, 1'b0));
    send(1, D1, 0, 9, fr(8'h55, 1'b0));
    repeat (20 * D1) @(posedge clk);
    #1;
    idle(1, 3 * D1);
    push(1, mk(1'b0, 8'h3C, 1'b0, 1'b0));
    send(1, D1, 0, 9, fr(8'h3C, 1'b1));
    idle(1, 2 * D1);
    wait_drain(1, 4 * D1);

    // Overrun: consumer stalled across two deliveries
    ready[1] = 1'b0;
    push(1, mk(1'b0, 8'h11, 1'b0, 1'b0));
    send(1, D1, 0, 9, fr(8'h11, 1'b1));
    idle(1, 2 * D1);
    push(1, mk(1'b0, 8'h22, 1'b0, 1'b1));
    send(1, D1, 0, 9, fr(8'h22, 1'b1));
    idle(1, 2 * D1);
    wait_drain(1, 4 * D1);
    @(negedge clk);
    chk("stalled_valid_data", {valid1, data1}, {1'b1, 8'h22});
    @(posedge clk);
    #1 ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_clears_after_take", {31'b0, valid1}, 32'd0);
    @(posedge clk);
    #1;

    // Short low pulses on an idle line are glitches
    rxd[0] = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    idle(0, 2 * D0);
    rxd[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(1, 2 * D1);
    chk("glitch_quiet", {valid0, ferr0, valid1, ferr1}, '0);
    push(1, mk(1'b0, 8'h96, 1'b0, 1'b0));
    send(1, D1, 0, 9, fr(8'h96, 1'b1));
    idle(1, 2 * D1);
    wait_drain(1, 4 * D1);

    // Reset in the middle of data bit 4 of 0x7E, held for the rest of the frame
    ready[1] = 1'b0;
    push(1, mk(1'b0, 8'h5A, 1'b0, 1'b0));
    send(1, D1, 0, 9, fr(8'h5A, 1'b1));
    idle(1, 2 * D1);
    wait_drain(1, 4 * D1);
    chk("pre_reset_held", {valid1, data1}, {1'b1, 8'h5A});
    send(1, D1, 0, 4, fr(8'h7E, 1'b1));
    rxd[1] = 1'b1;  // data bit 4 of 0x7E
    repeat (D1 / 2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (D1 - D1 / 2) @(posedge clk);
    #1;
    send(1, D1, 6, 9, fr(8'h7E, 1'b1));
    idle(1, D1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_frame_reset_d1", {valid1, perr1, ferr1, ovr1, data1}, '0);
    @(posedge clk);
    #1 ready[1] = 1'b1;
    idle(1, 3 * D1);
    chk("no_word_after_reset", {31'b0, valid1}, 32'd0);
    push(1, mk(1'b0, 8'h81, 1'b0, 1'b0));
    send(1, D1, 0, 9, fr(8'h81, 1'b1));
    idle(1, 2 * D1);
    wait_drain(1, 4 * D1);

    repeat (10) @(posedge clk);
    #1;
    chk("queue0_empty", qsize(0), 32'd0);
    chk("queue1_empty", qsize(1), 32'd0);
    chk("queue2_empty", qsize(2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
